// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path and the word framing controller.
package uart_pkg;

    // Default bit period shared with uart_rx.
    localparam int unsigned CLKS_PER_BIT = 434;

    // First byte of every frame.
    localparam logic [7:0] UART_SYNC_BYTE = 8'hA5;

    // Frame collection states.
    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        GET_LSB = 2'd1,
        GET_MSB = 2'd2,
        GET_CHK = 2'd3
    } frame_state_e;

    // Expected check byte for a frame carrying {msb, lsb}.
    function automatic logic [7:0] frame_chk(input logic [7:0] lsb, input logic [7:0] msb);
        return UART_SYNC_BYTE ^ lsb ^ msb;
    endfunction

endpackage

// File: rtl/uart_word_ctrl_if.sv
// Byte-strobe input and word valid/ready output of the framing controller.
interface uart_word_ctrl_if;

    logic        i_RX_DV;
    logic [7:0]  i_RX_Byte;
    logic [15:0] o_Word;
    logic        o_Word_Valid;
    logic        i_Word_Ready;

    // Controller side.
    modport master (
        input  i_RX_DV,
        input  i_RX_Byte,
        input  i_Word_Ready,
        output o_Word,
        output o_Word_Valid
    );

    // Byte source / word consumer side.
    modport slave (
        output i_RX_DV,
        output i_RX_Byte,
        output i_Word_Ready,
        input  o_Word,
        input  o_Word_Valid
    );

endinterface

// File: rtl/uart_word_fifo.sv
// First-word fall-through FIFO; a push while full is taken if a pop happens in the same cycle.
module uart_word_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_Clock,
    input  logic             i_Rst_n,
    input  logic             i_Push,
    input  logic [WIDTH-1:0] i_Data,
    input  logic             i_Pop,
    output logic [WIDTH-1:0] o_Data,
    output logic             o_Empty,
    output logic             o_Full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_en;
    logic             push_en;

    assign o_Empty = (count_q == '0);
    assign o_Full  = (count_q == CW'(DEPTH));
    assign o_Data  = mem_q[rd_ptr_q];

    // Next pointers, occupancy and storage contents.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_en   = i_Pop && !o_Empty;
        push_en  = i_Push && (!o_Full || pop_en);
        if (push_en) begin
            mem_d[wr_ptr_q] = i_Data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers, cleared asynchronously.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_word_ctrl.sv
// Turns uart_rx byte strobes into checksummed 16-bit words queued for a valid/ready consumer.
module uart_word_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CLKS = 9548,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic             i_Clock,
    input  logic             i_Rst_n,
    uart_word_ctrl_if.master bus,
    output logic             o_Err_Chk,
    output logic             o_Err_Timeout,
    output logic             o_Err_Ovf,
    output logic [7:0]       o_Frame_Count
);

    // Counter value one below the timeout point; reaching it ends the frame.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CLKS - 2);

    frame_state_e state_q, state_d;
    logic [7:0]   lsb_q, lsb_d;
    logic [7:0]   msb_q, msb_d;
    logic [15:0]  tmo_cnt_q, tmo_cnt_d;
    logic         err_chk_q, err_chk_d;
    logic         err_tmo_q, err_tmo_d;
    logic         err_ovf_q, err_ovf_d;
    logic [7:0]   frame_cnt_q, frame_cnt_d;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_empty;
    logic         fifo_full;
    logic [15:0]  fifo_data;

    assign bus.o_Word       = fifo_data;
    assign bus.o_Word_Valid = !fifo_empty;
    assign o_Err_Chk        = err_chk_q;
    assign o_Err_Timeout    = err_tmo_q;
    assign o_Err_Ovf        = err_ovf_q;
    assign o_Frame_Count    = frame_cnt_q;

    // Frame FSM, inter-byte timeout, checksum compare and FIFO push decision.
    always_comb begin
        state_d     = state_q;
        lsb_d       = lsb_q;
        msb_d       = msb_q;
        tmo_cnt_d   = tmo_cnt_q;
        err_chk_d   = 1'b0;
        err_tmo_d   = 1'b0;
        err_ovf_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        fifo_push   = 1'b0;
        fifo_pop    = !fifo_empty && bus.i_Word_Ready;

        if (bus.i_RX_DV) begin
            // A strobe always restarts the timeout, even on the cycle it would expire.
            tmo_cnt_d = '0;
            case (state_q)
                HUNT: begin
                    if (bus.i_RX_Byte == UART_SYNC_BYTE) begin
                        state_d = GET_LSB;
                    end
                end
                GET_LSB: begin
                    lsb_d   = bus.i_RX_Byte;
                    state_d = GET_MSB;
                end
                GET_MSB: begin
                    msb_d   = bus.i_RX_Byte;
                    state_d = GET_CHK;
                end
                GET_CHK: begin
                    state_d = HUNT;
                    if (bus.i_RX_Byte == frame_chk(lsb_q, msb_q)) begin
                        if (!fifo_full || fifo_pop) begin
                            fifo_push   = 1'b1;
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end else begin
                            err_ovf_d = 1'b1;
                        end
                    end else begin
                        err_chk_d = 1'b1;
                    end
                end
            endcase
        end else if (state_q != HUNT) begin
            if (tmo_cnt_q == TMO_LAST) begin
                state_d   = HUNT;
                err_tmo_d = 1'b1;
                tmo_cnt_d = '0;
                lsb_d     = '0;
                msb_d     = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end else begin
            tmo_cnt_d = '0;
        end
    end

    // Controller state, error pulse and frame count registers.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= HUNT;
            lsb_q       <= '0;
            msb_q       <= '0;
            tmo_cnt_q   <= '0;
            err_chk_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lsb_q       <= lsb_d;
            msb_q       <= msb_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_chk_q   <= err_chk_d;
            err_tmo_q   <= err_tmo_d;
            err_ovf_q   <= err_ovf_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    uart_word_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .i_Push  (fifo_push),
        .i_Data  ({msb_q, lsb_q}),
        .i_Pop   (fifo_pop),
        .o_Data  (fifo_data),
        .o_Empty (fifo_empty),
        .o_Full  (fifo_full)
    );

endmodule

// File: tb/tb_uart_word_ctrl.sv
// Scoreboard bench for uart_word_ctrl: stimulus queues expected words, a monitor checks each handshake.
module tb_uart_word_ctrl;

    localparam int unsigned T = 24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       err_chk;
    logic       err_tmo;
    logic       err_ovf;
    logic [7:0] frame_count;

    always #5 clk = ~clk;

    uart_word_ctrl_if bus();

    uart_word_ctrl #(
        .TIMEOUT_CLKS (T),
        .FIFO_DEPTH   (4)
    ) dut (
        .i_Clock       (clk),
        .i_Rst_n       (rst_n),
        .bus           (bus),
        .o_Err_Chk     (err_chk),
        .o_Err_Timeout (err_tmo),
        .o_Err_Ovf     (err_ovf),
        .o_Frame_Count (frame_count)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_chk = 0;
    int n_tmo = 0;
    int n_ovf = 0;
    int tmo_cyc = -1;
    int last_strobe = 0;
    logic [15:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts error pulses and scores every accepted word against the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_chk) n_chk++;
            if (err_tmo) begin
                n_tmo++;
                tmo_cyc = cyc;
            end
            if (err_ovf) n_ovf++;
            if (bus.o_Word_Valid && bus.i_Word_Ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", bus.o_Word);
                end else begin
                    check("word", {16'h0, bus.o_Word}, {16'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_RX_DV   = 1'b1;
        bus.i_RX_Byte = b;
        last_strobe   = cyc;
        @(posedge clk);
        #1;
        bus.i_RX_DV   = 1'b0;
        bus.i_RX_Byte = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] lsb, input logic [7:0] msb,
                              input logic [7:0] chk, input bit accept);
        if (accept) exp_q.push_back({msb, lsb});
        send_byte(8'hA5);
        send_byte(lsb);
        send_byte(msb);
        send_byte(chk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        bus.i_Word_Ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            idle(1);
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        idle(1);
        check({name, "_empty"}, bus.o_Word_Valid, 0);
    endtask

    initial begin
        int l;
        bus.i_RX_DV      = 1'b0;
        bus.i_RX_Byte    = 8'h00;
        bus.i_Word_Ready = 1'b1;

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.o_Word_Valid, 0);
        check("rst_word", bus.o_Word, 16'h0000);
        check("rst_errs", {err_chk, err_tmo, err_ovf}, 0);
        check("rst_count", frame_count, 0);
        rst_n = 1'b1;
        idle(2);

        // Good frame, word visible exactly one cycle with ready high
        send_frame(8'h34, 8'h12, 8'h83, 1);
        check("good_valid", bus.o_Word_Valid, 1);
        check("good_word", bus.o_Word, 16'h1234);
        check("good_count", frame_count, 1);
        idle(1);
        check("good_valid_1cyc", bus.o_Word_Valid, 0);
        check("good_no_err", n_chk + n_tmo + n_ovf, 0);

        // Junk before sync, then bad checksum
        send_byte(8'h00);
        send_byte(8'h7E);
        send_frame(8'h34, 8'h12, 8'h84, 0);
        idle(2);
        check("chk_pulses", n_chk, 1);
        check("chk_empty", bus.o_Word_Valid, 0);
        check("chk_count", frame_count, 1);

        // Timeout after partial frame, exact pulse cycle
        send_byte(8'hA5);
        send_byte(8'h34);
        l = last_strobe;
        idle(T + 3);
        check("tmo_pulses", n_tmo, 1);
        check("tmo_cycle", tmo_cyc, l + T);
        send_frame(8'hCD, 8'hAB, 8'hC3, 1);
        idle(2);
        check("tmo_recover_count", frame_count, 2);
        check("tmo_recover_sb", exp_q.size(), 0);

        // Strobe on the cycle the timeout would fire
        exp_q.push_back(16'h5678);
        send_byte(8'hA5);
        idle(T - 2);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h8B);
        idle(2);
        check("edge_no_tmo", n_tmo, 1);
        check("edge_count", frame_count, 3);
        check("edge_sb", exp_q.size(), 0);

        // Overflow with consumer stalled
        bus.i_Word_Ready = 1'b0;
        send_frame(8'h01, 8'h00, 8'hA4, 1);
        send_frame(8'h02, 8'h00, 8'hA7, 1);
        send_frame(8'h03, 8'h00, 8'hA6, 1);
        send_frame(8'h04, 8'h00, 8'hA1, 1);
        send_frame(8'h05, 8'h00, 8'hA0, 0);
        idle(2);
        check("ovf_pulses", n_ovf, 1);
        check("ovf_count", frame_count, 7);
        check("ovf_head", bus.o_Word, 16'h0001);
        drain("ovf");

        // Full FIFO with a pop coinciding with the CHK strobe
        bus.i_Word_Ready = 1'b0;
        send_frame(8'h11, 8'h00, 8'hB4, 1);
        send_frame(8'h12, 8'h00, 8'hB7, 1);
        send_frame(8'h13, 8'h00, 8'hB6, 1);
        send_frame(8'h14, 8'h00, 8'hB1, 1);
        exp_q.push_back(16'h0015);
        send_byte(8'hA5);
        send_byte(8'h15);
        send_byte(8'h00);
        bus.i_Word_Ready = 1'b1;
        send_byte(8'hB0);
        idle(2);
        check("popchk_no_ovf", n_ovf, 1);
        check("popchk_count", frame_count, 12);
        drain("popchk");

        // Reset in GET_MSB with two words queued
        bus.i_Word_Ready = 1'b0;
        send_frame(8'h21, 8'h00, 8'h84, 1);
        send_frame(8'h22, 8'h00, 8'h87, 1);
        send_byte(8'hA5);
        send_byte(8'h31);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.o_Word_Valid, 0);
        check("mid_rst_count", frame_count, 0);
        check("mid_rst_word", bus.o_Word, 16'h0000);
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        idle(1);
        bus.i_Word_Ready = 1'b1;
        send_frame(8'h42, 8'h00, 8'hE7, 1);
        idle(2);
        check("post_rst_count", frame_count, 1);
        check("post_rst_sb", exp_q.size(), 0);

        check("final_chk", n_chk, 1);
        check("final_tmo", n_tmo, 1);
        check("final_ovf", n_ovf, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
